mux_sel_ctrl: RTL and testbench



---
 rtl/mux_sel_ctrl.sv | 146 ++++++++++++++
 tb/tb_mux_sel_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_ctrl.sv
// mux_sel_ctrl: sequencing controller for the 5-bit project-select mux.
// Synchronises the three control pins, keeps a target project index and
// switches the mux address with break-before-make sequencing, so that no
// project ever sees addr change while it is enabled.
module mux_sel_ctrl #(
  parameter int NUM_PROJECTS = 8,
  parameter int GUARD_CYCLES = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel_rst,
  input  logic       sel_inc,
  input  logic       sel_ena,
  output logic [4:0] addr,
  output logic       ena,
  output logic       busy
);

  localparam int               CNT_W      = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [4:0]       LAST_IDX   = 5'(NUM_PROJECTS - 1);

  typedef enum logic [1:0] {
    OFF,
    SETTLE,
    ON,
    DRAIN
  } state_t;

  logic [SYNC_STAGES-1:0] rst_sync;
  logic [SYNC_STAGES-1:0] inc_sync;
  logic [SYNC_STAGES-1:0] ena_sync;
  logic                   s_rst;
  logic                   s_inc;
  logic                   s_ena;
  logic                   s_inc_d;
  logic                   inc_edge;

  logic [4:0]             tgt;

  state_t                 state_q;
  state_t                 state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic [4:0]             addr_q;
  logic [4:0]             addr_d;
  logic                   ena_q;

  // Pin synchronisers: each pad shifts through SYNC_STAGES flops, plus one
  // extra flop on the increment pin so its rising edge can be detected.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_sync <= '0;
      inc_sync <= '0;
      ena_sync <= '0;
      s_inc_d  <= 1'b0;
    end else begin
      rst_sync <= {rst_sync[SYNC_STAGES-2:0], sel_rst};
      inc_sync <= {inc_sync[SYNC_STAGES-2:0], sel_inc};
      ena_sync <= {ena_sync[SYNC_STAGES-2:0], sel_ena};
      s_inc_d  <= s_inc;
    end
  end

  assign s_rst    = rst_sync[SYNC_STAGES-1];
  assign s_inc    = inc_sync[SYNC_STAGES-1];
  assign s_ena    = ena_sync[SYNC_STAGES-1];
  assign inc_edge = s_inc & ~s_inc_d;

  // Target index: the reset pin wins over a coincident increment edge, and
  // the increment wraps after the last populated slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt <= '0;
    end else if (s_rst) begin
      tgt <= '0;
    end else if (inc_edge) begin
      tgt <= (tgt == LAST_IDX) ? 5'd0 : tgt + 5'd1;
    end
  end

  // Sequencer next state: addr may only follow tgt while OFF; SETTLE can be
  // aborted but DRAIN always runs its full guard time before OFF.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      OFF: begin
        addr_d = tgt;
        if (s_ena && (addr_q == tgt)) begin
          state_d = SETTLE;
          cnt_d   = GUARD_LOAD;
        end
      end
      SETTLE: begin
        if (!s_ena || (tgt != addr_q)) begin
          state_d = OFF;
        end else if (cnt_q == '0) begin
          state_d = ON;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ON: begin
        if (!s_ena || (tgt != addr_q)) begin
          state_d = DRAIN;
          cnt_d   = GUARD_LOAD;
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = OFF;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = OFF;
      end
    endcase
  end

  // Sequencer registers: ena is registered from the next state so it is high
  // exactly while the state register holds ON and cannot glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OFF;
      cnt_q   <= '0;
      addr_q  <= '0;
      ena_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ena_q   <= (state_d == ON);
    end
  end

  assign addr = addr_q;
  assign ena  = ena_q;
  assign busy = (state_q == SETTLE) || (state_q == DRAIN) || (tgt != addr_q);

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// tb_mux_sel_ctrl: directed, table-driven bench for mux_sel_ctrl with the
// default parameters (8 projects, 4 guard cycles, 2 sync stages).
module tb_mux_sel_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel_rst;
  logic       sel_inc;
  logic       sel_ena;
  logic [4:0] addr;
  logic       ena;
  logic       busy;

  int         compared   = 0;
  int         mismatched = 0;
  int         violations = 0;
  int         ena_highs  = 0;
  logic [4:0] prev_addr  = '0;
  logic       prev_ena   = 1'b0;

  typedef struct {
    logic       rst_in;
    logic       rst_pin;
    logic       inc_pin;
    logic       ena_pin;
    logic [4:0] exp_addr;
    logic       exp_ena;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  mux_sel_ctrl #(
    .NUM_PROJECTS(8),
    .GUARD_CYCLES(4),
    .SYNC_STAGES (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sel_rst(sel_rst),
    .sel_inc(sel_inc),
    .sel_ena(sel_ena),
    .addr   (addr),
    .ena    (ena),
    .busy   (busy)
  );

  // Advance one clock edge and sample 1 unit later; also watch that addr
  // never moves in a cycle where ena is, or just was, high.
  task automatic step();
    @(posedge clk);
    #1;
    if (((ena === 1'b1) || (prev_ena === 1'b1)) && (addr !== prev_addr)) violations++;
    if (ena === 1'b1) ena_highs++;
    prev_addr = addr;
    prev_ena  = ena;
  endtask

  task automatic applyStimulus(input logic r, input logic sr, input logic inc, input logic en);
    rst     = r;
    sel_rst = sr;
    sel_inc = inc;
    sel_ena = en;
  endtask

  task automatic checkOutput(input string name, input logic [4:0] ea, input logic ee, input logic eb);
    compared++;
    if ((addr !== ea) || (ena !== ee) || (busy !== eb)) begin
      mismatched++;
      $display("[TB] FAIL %s: got addr=%0d ena=%b busy=%b, expected addr=%0d ena=%b busy=%b",
               name, addr, ena, busy, ea, ee, eb);
    end
  endtask

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic addVec(input logic r, input logic sr, input logic inc, input logic en,
                        input logic [4:0] ea, input logic ee, input logic eb);
    vec_t v;
    v.rst_in   = r;
    v.rst_pin  = sr;
    v.inc_pin  = inc;
    v.ena_pin  = en;
    v.exp_addr = ea;
    v.exp_ena  = ee;
    v.exp_busy = eb;
    vecs.push_back(v);
  endtask

  // One increment pulse while disabled: 1 cycle high, 3 low; addr has
  // followed the new target by the end of the 4th cycle.
  task automatic pulseInc();
    applyStimulus(1'b0, 1'b0, 1'b1, sel_ena);
    step();
    sel_inc = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    logic [4:0] prev_idx;
    logic [4:0] next_idx;

    // Reset, then sel_ena held: ena rises on the 7th edge (2 sync + 1 + 4 guard).
    addVec(1, 0, 0, 0, 5'd0, 0, 0);
    addVec(0, 0, 0, 1, 5'd0, 0, 0);
    addVec(0, 0, 0, 1, 5'd0, 0, 0);
    addVec(0, 0, 0, 1, 5'd0, 0, 1);
    addVec(0, 0, 0, 1, 5'd0, 0, 1);
    addVec(0, 0, 0, 1, 5'd0, 0, 1);
    addVec(0, 0, 0, 1, 5'd0, 0, 1);
    addVec(0, 0, 0, 1, 5'd0, 1, 0);
    addVec(0, 0, 0, 1, 5'd0, 1, 0);
    // Drop sel_ena: ena falls on the 3rd edge, DRAIN lasts 4 cycles.
    addVec(0, 0, 0, 0, 5'd0, 1, 0);
    addVec(0, 0, 0, 0, 5'd0, 1, 0);
    addVec(0, 0, 0, 0, 5'd0, 0, 1);
    addVec(0, 0, 0, 0, 5'd0, 0, 1);
    addVec(0, 0, 0, 0, 5'd0, 0, 1);
    addVec(0, 0, 0, 0, 5'd0, 0, 1);
    addVec(0, 0, 0, 0, 5'd0, 0, 0);
    // Eight increment pulses while disabled: addr steps 1..7 then wraps to 0,
    // with busy high for the one cycle where tgt leads addr.
    prev_idx = 5'd0;
    for (int p = 0; p < 8; p++) begin
      next_idx = (p == 7) ? 5'd0 : prev_idx + 5'd1;
      addVec(0, 0, 1, 0, prev_idx, 0, 0);
      addVec(0, 0, 0, 0, prev_idx, 0, 0);
      addVec(0, 0, 0, 0, prev_idx, 0, 1);
      addVec(0, 0, 0, 0, next_idx, 0, 0);
      prev_idx = next_idx;
    end

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst_in, vecs[i].rst_pin, vecs[i].inc_pin, vecs[i].ena_pin);
      step();
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_ena, vecs[i].exp_busy);
    end

    // Enabled at addr 0, one increment pulse: ena low from edge 4, addr
    // moves to 1 on edge 9, ena back on edge 14.
    applyStimulus(0, 0, 0, 1);
    repeat (7) step();
    checkOutput("seqA enabled at 0", 5'd0, 1'b1, 1'b0);
    applyStimulus(0, 0, 1, 1);
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 1) sel_inc = 1'b0;
      checkField($sformatf("seqA ena edge%0d", k), 32'(ena), ((k <= 3) || (k >= 14)) ? 32'd1 : 32'd0);
      checkField($sformatf("seqA addr edge%0d", k), 32'(addr), (k <= 8) ? 32'd0 : 32'd1);
    end

    // sel_ena dropped while SETTLE is still counting: back to OFF, no ena pulse.
    applyStimulus(0, 0, 0, 0);
    repeat (7) step();
    checkOutput("seqB idle at 1", 5'd1, 1'b0, 1'b0);
    ena_highs = 0;
    applyStimulus(0, 0, 0, 1);
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 3) begin
        checkField("seqB in SETTLE busy", 32'(busy), 32'd1);
        sel_ena = 1'b0;
      end
      if (k == 5) checkField("seqB still SETTLE busy", 32'(busy), 32'd1);
      if (k == 6) checkField("seqB aborted busy", 32'(busy), 32'd0);
    end
    checkField("seqB ena pulses", 32'(ena_highs), 32'd0);

    // sel_rst and sel_inc rising together with tgt=5 while enabled: tgt goes
    // to 0 rather than 6, and addr follows through DRAIN.
    repeat (4) pulseInc();
    checkOutput("seqC idle at 5", 5'd5, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 1);
    repeat (7) step();
    checkOutput("seqC enabled at 5", 5'd5, 1'b1, 1'b0);
    applyStimulus(0, 1, 1, 1);
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 1) begin
        sel_rst = 1'b0;
        sel_inc = 1'b0;
      end
      if (k == 3)  checkOutput("seqC tgt reset", 5'd5, 1'b1, 1'b1);
      if (k == 4)  checkOutput("seqC drain start", 5'd5, 1'b0, 1'b1);
      if (k == 8)  checkOutput("seqC drain done", 5'd5, 1'b0, 1'b1);
      if (k == 9)  checkOutput("seqC addr to 0", 5'd0, 1'b0, 1'b0);
      if (k == 13) checkOutput("seqC settling", 5'd0, 1'b0, 1'b1);
      if (k == 14) checkOutput("seqC re-enabled", 5'd0, 1'b1, 1'b0);
    end

    // rst asserted during DRAIN at addr 3: everything returns to idle at 0.
    applyStimulus(0, 0, 0, 0);
    repeat (7) step();
    repeat (3) pulseInc();
    applyStimulus(0, 0, 0, 1);
    repeat (7) step();
    checkOutput("seqD enabled at 3", 5'd3, 1'b1, 1'b0);
    applyStimulus(0, 0, 0, 0);
    repeat (4) step();
    checkOutput("seqD in DRAIN", 5'd3, 1'b0, 1'b1);
    applyStimulus(1, 0, 0, 0);
    step();
    checkOutput("seqD reset edge", 5'd0, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 0);
    step();
    checkOutput("seqD after release", 5'd0, 1'b0, 1'b0);
    // Synchronisers were cleared too, so the full enable latency applies again.
    applyStimulus(0, 0, 0, 1);
    repeat (6) step();
    checkField("seqD ena before 7th edge", 32'(ena), 32'd0);
    step();
    checkOutput("seqD ena on 7th edge", 5'd0, 1'b1, 1'b0);

    checkField("no addr change while enabled", 32'(violations), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
